// File: rtl/branch_resolve_ctrl_if.sv
// Interface between the decode stage and the branch scheduler.
// The decode side (master) drives the instruction, operands and flush.
// The scheduler (slave) returns stall, redirect, link-write and statistics.
interface branch_resolve_ctrl_if #(
   parameter int STAT_W = 16
);
   logic              br_valid_i;
   logic [5:0]        op_i;
   logic [4:0]        rt_i;
   logic [31:0]       a_i;
   logic [31:0]       b_i;
   logic              a_ready_i;
   logic              b_ready_i;
   logic [31:0]       target_i;
   logic [31:0]       link_i;
   logic              flush_i;
   logic              stall_o;
   logic              redirect_o;
   logic [31:0]       redirect_pc_o;
   logic              link_we_o;
   logic [31:0]       link_data_o;
   logic              timeout_o;
   logic [STAT_W-1:0] br_count_o;
   logic [STAT_W-1:0] taken_count_o;

   modport master (
      output br_valid_i, op_i, rt_i, a_i, b_i, a_ready_i, b_ready_i,
             target_i, link_i, flush_i,
      input  stall_o, redirect_o, redirect_pc_o, link_we_o, link_data_o,
             timeout_o, br_count_o, taken_count_o
   );

   modport slave (
      input  br_valid_i, op_i, rt_i, a_i, b_i, a_ready_i, b_ready_i,
             target_i, link_i, flush_i,
      output stall_o, redirect_o, redirect_pc_o, link_we_o, link_data_o,
             timeout_o, br_count_o, taken_count_o
   );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Decode-stage branch scheduler for the MIPS pipeline.
// Accepts a decoded branch, holds decode until the operands it needs are
// hazard-free, then resolves the condition from the captured operands and
// issues the PC redirect and the $31 link write for BGEZAL/BLTZAL.
// Optional feature macro: BRANCH_STATS_EN builds the saturating
// resolved/taken statistics counters; without it both counts read 0.
module branch_resolve_ctrl #(
   parameter int MAX_WAIT = 15,
   parameter int STAT_W   = 16
) (
   input logic                 clk,
   input logic                 rst,
   branch_resolve_ctrl_if.slave bus
);

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      EVAL = 2'd2
   } state_t;

   state_t      state;
   logic [5:0]  op_q;
   logic [4:0]  rt_q;
   logic [31:0] target_q;
   logic [31:0] link_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        a_cap;
   logic        b_cap;
   logic [7:0]  wait_cnt;
   logic        timeout_q;

   logic        accept;
   logic        a_have;
   logic        b_have;
   logic        taken;
   logic        eval_fire;

   // Recognise the supported branch encodings; anything else passes through.
   function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt);
      logic res;
      res = 1'b0;
      case (op)
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: res = 1'b1;
         OP_REGIMM: res = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                          (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
         default: res = 1'b0;
      endcase
      return res;
   endfunction

   // Only the two-register compares depend on the rt operand.
   function automatic logic needs_b(input logic [5:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

   // The and-link variants write PC+8 to $31 whatever the outcome.
   function automatic logic is_link(input logic [5:0] op, input logic [4:0] rt);
      return (op == OP_REGIMM) && ((rt == RT_BLTZAL) || (rt == RT_BGEZAL));
   endfunction

   // A new branch is taken on only from IDLE and never in a flush cycle.
   assign accept = (state == IDLE) && bus.br_valid_i &&
                   is_branch(bus.op_i, bus.rt_i) && !bus.flush_i;

   // Operand availability while waiting counts this cycle's ready bits too.
   assign a_have = a_cap || bus.a_ready_i;
   assign b_have = b_cap || bus.b_ready_i || !needs_b(op_q);

   // Branch condition evaluated only from the captured operand registers.
   always_comb begin
      taken = 1'b0;
      case (op_q)
         OP_BEQ:    taken = (a_q == b_q);
         OP_BNE:    taken = (a_q != b_q);
         OP_BLEZ:   taken = ($signed(a_q) <= 32'sd0);
         OP_BGTZ:   taken = ($signed(a_q) > 32'sd0);
         OP_REGIMM: taken = rt_q[0] ? !a_q[31] : a_q[31];
         default:   taken = 1'b0;
      endcase
   end

   // A flush in the evaluate cycle wins over the branch outcome.
   assign eval_fire = (state == EVAL) && !bus.flush_i;

   assign bus.stall_o       = !bus.flush_i && (accept || (state == WAIT));
   assign bus.redirect_o    = eval_fire && taken;
   assign bus.redirect_pc_o = (eval_fire && taken) ? target_q : 32'h0;
   assign bus.link_we_o     = eval_fire && is_link(op_q, rt_q);
   assign bus.link_data_o   = link_q;
   assign bus.timeout_o     = timeout_q;

   // Scheduler state machine: accept, collect operands, evaluate, or give up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= '0;
         rt_q      <= '0;
         target_q  <= '0;
         link_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         a_cap     <= 1'b0;
         b_cap     <= 1'b0;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else if (bus.flush_i) begin
         state    <= IDLE;
         a_cap    <= 1'b0;
         b_cap    <= 1'b0;
         wait_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  op_q     <= bus.op_i;
                  rt_q     <= bus.rt_i;
                  target_q <= bus.target_i;
                  link_q   <= bus.link_i;
                  a_cap    <= bus.a_ready_i;
                  b_cap    <= bus.b_ready_i;
                  wait_cnt <= '0;
                  if (bus.a_ready_i) a_q <= bus.a_i;
                  if (bus.b_ready_i) b_q <= bus.b_i;
                  if (bus.a_ready_i && (bus.b_ready_i || !needs_b(bus.op_i)))
                     state <= EVAL;
                  else
                     state <= WAIT;
               end
            end
            WAIT: begin
               if (!a_cap && bus.a_ready_i) begin
                  a_q   <= bus.a_i;
                  a_cap <= 1'b1;
               end
               if (!b_cap && bus.b_ready_i) begin
                  b_q   <= bus.b_i;
                  b_cap <= 1'b1;
               end
               if (a_have && b_have) begin
                  state <= EVAL;
               end else if (wait_cnt == WAIT_LAST) begin
                  timeout_q <= 1'b1;
                  a_cap     <= 1'b0;
                  b_cap     <= 1'b0;
                  state     <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            EVAL: begin
               a_cap <= 1'b0;
               b_cap <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   logic [STAT_W-1:0] br_cnt;
   logic [STAT_W-1:0] taken_cnt;

   // Saturating counts of resolved and taken branches, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt    <= '0;
         taken_cnt <= '0;
      end else if (eval_fire) begin
         if (br_cnt != {STAT_W{1'b1}}) br_cnt <= br_cnt + 1'b1;
         if (taken && (taken_cnt != {STAT_W{1'b1}})) taken_cnt <= taken_cnt + 1'b1;
      end
   end

   assign bus.br_count_o    = br_cnt;
   assign bus.taken_count_o = taken_cnt;
`else
   assign bus.br_count_o    = {STAT_W{1'b0}};
   assign bus.taken_count_o = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl.
// Each driven cycle pushes the outputs expected for that cycle onto a
// scoreboard; a monitor on the falling edge pops and compares them.
module tb_branch_resolve_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   passed;

   branch_resolve_ctrl_if #(.STAT_W(16)) bus ();

   branch_resolve_ctrl #(.MAX_WAIT(15), .STAT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      string       tag;
      logic        stall;
      logic        redir;
      logic [31:0] pc;
      logic        lwe;
      logic [31:0] link;
      logic        tim;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] cur_tgt;
   logic [31:0] cur_link;
   logic        exp_tim;

`ifdef BRANCH_STATS_EN
   localparam int MID_BR = 6, MID_TK = 4, END_BR = 1, END_TK = 1;
`else
   localparam int MID_BR = 0, MID_TK = 0, END_BR = 0, END_TK = 0;
`endif

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
   endtask

   // Drive one cycle of decode inputs and queue the outputs expected in it.
   task automatic applyStimulus(input string tag, input logic valid, input logic [5:0] op,
                                input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b,
                                input logic ar, input logic brdy, input logic flush,
                                input logic e_stall, input logic e_redir, input logic e_lwe);
      exp_t e;
      @(posedge clk);
      #1;
      bus.br_valid_i = valid;
      bus.op_i       = op;
      bus.rt_i       = rt;
      bus.a_i        = a;
      bus.b_i        = b;
      bus.a_ready_i  = ar;
      bus.b_ready_i  = brdy;
      bus.target_i   = cur_tgt;
      bus.link_i     = cur_link;
      bus.flush_i    = flush;
      e.tag   = tag;
      e.stall = e_stall;
      e.redir = e_redir;
      e.pc    = e_redir ? cur_tgt : 32'h0;
      e.lwe   = e_lwe;
      e.link  = cur_link;
      e.tim   = exp_tim;
      sb.push_back(e);
   endtask

   task automatic idleCycle(input string tag);
      applyStimulus(tag, 1'b0, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard monitor: compare the cycle's outputs away from the rising edge.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checkOutput({e.tag, ".stall"}, 32'(bus.stall_o), 32'(e.stall));
         checkOutput({e.tag, ".redirect"}, 32'(bus.redirect_o), 32'(e.redir));
         checkOutput({e.tag, ".pc"}, bus.redirect_pc_o, e.pc);
         checkOutput({e.tag, ".link_we"}, 32'(bus.link_we_o), 32'(e.lwe));
         checkOutput({e.tag, ".timeout"}, 32'(bus.timeout_o), 32'(e.tim));
         if (e.lwe) checkOutput({e.tag, ".link_data"}, bus.link_data_o, e.link);
      end
   end

   initial begin
      checks = 0;
      passed = 0;
      exp_tim = 1'b0;
      cur_tgt = 32'h0;
      cur_link = 32'h0;
      rst = 1'b1;
      bus.br_valid_i = 1'b0; bus.op_i = '0; bus.rt_i = '0;
      bus.a_i = '0; bus.b_i = '0; bus.a_ready_i = 1'b0; bus.b_ready_i = 1'b0;
      bus.target_i = '0; bus.link_i = '0; bus.flush_i = 1'b0;
      #12;
      checkOutput("rst.stall", 32'(bus.stall_o), 32'h0);
      checkOutput("rst.redirect", 32'(bus.redirect_o), 32'h0);
      checkOutput("rst.link_data", bus.link_data_o, 32'h0);
      checkOutput("rst.timeout", 32'(bus.timeout_o), 32'h0);
      checkOutput("rst.br_count", 32'(bus.br_count_o), 32'h0);
      #1 rst = 1'b0;

      // BEQ with equal operands ready at accept: one stall cycle then redirect.
      cur_tgt = 32'h0000_1000; cur_link = 32'h0000_2008;
      applyStimulus("beq.acc", 1'b1, 6'b000100, 5'd0, 32'h5, 32'h5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idleCycle("beq.eval_placeholder");
      sb[sb.size()-1].redir = 1'b1;
      sb[sb.size()-1].pc    = cur_tgt;

      // BGTZ with the most negative value: signed compare, not taken.
      cur_tgt = 32'h0000_2000;
      applyStimulus("bgtz.acc", 1'b1, 6'b000111, 5'd0, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idleCycle("bgtz.eval");

      // BLEZ with the same operand: taken.
      cur_tgt = 32'h0000_3000;
      applyStimulus("blez.acc", 1'b1, 6'b000110, 5'd0, 32'h8000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("blez.eval", 1'b0, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // BNE with rt operand late by three cycles: four stall cycles, then redirect.
      cur_tgt = 32'h0000_4000;
      applyStimulus("bne.acc", 1'b1, 6'b000101, 5'd0, 32'h1, 32'hDEAD, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("bne.w0", 1'b0, 6'd0, 5'd0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("bne.w1", 1'b0, 6'd0, 5'd0, 32'h0, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("bne.w2", 1'b0, 6'd0, 5'd0, 32'h0, 32'h2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("bne.eval", 1'b0, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

      // BLTZAL with positive operand: not taken but the link is still written.
      cur_tgt = 32'h0000_5000; cur_link = 32'h0000_5558;
      applyStimulus("bltzal.acc", 1'b1, 6'b000001, 5'b10000, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("bltzal.eval", 1'b0, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // BGEZAL with zero: taken and linked; rt readiness is irrelevant.
      cur_tgt = 32'h0000_6000; cur_link = 32'h0000_6668;
      applyStimulus("bgezal.acc", 1'b1, 6'b000001, 5'b10001, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("bgezal.eval", 1'b0, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      // A non-branch opcode is ignored and never stalls.
      applyStimulus("nonbr", 1'b1, 6'b000000, 5'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Flush in the evaluate cycle of a taken BEQ suppresses everything.
      cur_tgt = 32'h0000_7000;
      applyStimulus("flush.acc", 1'b1, 6'b000100, 5'd0, 32'h7, 32'h7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("flush.eval", 1'b0, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      // Flush alongside a new branch in IDLE: not accepted, stall masked.
      applyStimulus("flush.idle", 1'b1, 6'b000100, 5'd0, 32'h7, 32'h7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idleCycle("flush.after");

      // BLTZ whose operand never arrives: abandoned after 15 waiting cycles.
      cur_tgt = 32'h0000_8000;
      applyStimulus("tmo.acc", 1'b1, 6'b000001, 5'b00000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++)
         applyStimulus($sformatf("tmo.w%0d", i), 1'b0, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      exp_tim = 1'b1;
      idleCycle("tmo.after");
      idleCycle("tmo.sticky");

      @(negedge clk);
      #1;
      checkOutput("mid.br_count", 32'(bus.br_count_o), 32'(MID_BR));
      checkOutput("mid.taken_count", 32'(bus.taken_count_o), 32'(MID_TK));

      // Asynchronous reset while a BNE is waiting: immediate return to IDLE.
      cur_tgt = 32'h0000_9000;
      applyStimulus("arst.acc", 1'b1, 6'b000101, 5'd0, 32'h3, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idleCycle("arst.wait_placeholder");
      sb[sb.size()-1].stall = 1'b1;
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("arst.stall", 32'(bus.stall_o), 32'h0);
      checkOutput("arst.timeout", 32'(bus.timeout_o), 32'h0);
      checkOutput("arst.link_data", bus.link_data_o, 32'h0);
      #2 rst = 1'b0;
      exp_tim = 1'b0;

      // Normal operation after reset.
      cur_tgt = 32'h0000_A000;
      applyStimulus("post.acc", 1'b1, 6'b000100, 5'd0, 32'h9, 32'h9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus("post.eval", 1'b0, 6'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idleCycle("post.idle");

      @(negedge clk);
      #1;
      checkOutput("end.br_count", 32'(bus.br_count_o), 32'(END_BR));
      checkOutput("end.taken_count", 32'(bus.taken_count_o), 32'(END_TK));
      checkOutput("sb.drain", 32'(sb.size()), 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
